// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, consumes the 1-cycle-latency instruction word, loads IF/ID.
// Optional FETCH_PERF_CNT_EN enables the emitted-instruction counter on fetch_count.
module fetch_unit #(
  parameter int                   Num_of_bits = 16,
  parameter int                   pc_width    = 32,
  parameter int                   OPCODE_W    = 5,
  parameter logic [OPCODE_W-1:0]  LDM_OPCODE  = 5'b10110,
  parameter logic [pc_width-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [pc_width-1:0]    branch_target,
  input  logic [Num_of_bits-1:0] instr_in,
  output logic [pc_width-1:0]    pc,
  output logic [Num_of_bits-1:0] if_id_instr,
  output logic [Num_of_bits-1:0] if_id_imm,
  output logic [pc_width-1:0]    if_id_pc,
  output logic                   if_id_valid,
  output logic [31:0]            fetch_count
);

  typedef enum logic {S_FETCH, S_IMM} state_t;

  localparam logic [pc_width-1:0] PC_ONE = pc_width'(1);

  state_t                 state, state_nxt;
  logic [pc_width-1:0]    next_pc, tag, hold_pc;
  logic                   word_valid;
  logic [Num_of_bits-1:0] hold_instr;
  logic                   is_ldm, emit, capture;

  assign is_ldm = (instr_in[Num_of_bits-1 -: OPCODE_W] == LDM_OPCODE);

  // Stall re-issues the tag so the memory keeps presenting the same word.
  always_comb begin
    pc = next_pc;
    if (rst)               pc = RESET_PC;
    else if (branch_taken) pc = branch_target;
    else if (stall)        pc = tag;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    capture   = 1'b0;
    if (rst || branch_taken) begin
      state_nxt = S_FETCH;
    end else if (!stall && word_valid) begin
      case (state)
        S_FETCH: begin
          if (is_ldm) begin
            capture   = 1'b1;
            state_nxt = S_IMM;
          end else begin
            emit = 1'b1;
          end
        end
        S_IMM: begin
          emit      = 1'b1;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc     <= RESET_PC;
      tag         <= RESET_PC;
      word_valid  <= 1'b0;
      hold_instr  <= '0;
      hold_pc     <= '0;
      if_id_instr <= '0;
      if_id_imm   <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      // In-flight word and any held LDM opcode word are squashed.
      tag         <= branch_target;
      next_pc     <= branch_target + PC_ONE;
      word_valid  <= 1'b1;
      hold_instr  <= '0;
      hold_pc     <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      tag        <= next_pc;
      next_pc    <= next_pc + PC_ONE;
      word_valid <= 1'b1;
      if (capture) begin
        hold_instr <= instr_in;
        hold_pc    <= tag;
      end
      if (emit) begin
        if (state == S_IMM) begin
          if_id_instr <= hold_instr;
          if_id_pc    <= hold_pc;
          if_id_imm   <= instr_in;
        end else begin
          if_id_instr <= instr_in;
          if_id_pc    <= tag;
          if_id_imm   <= '0;
        end
      end
      if_id_valid <= emit;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (emit) cnt <= cnt + 32'd1;
  end
  assign fetch_count = cnt;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: program-order reference model plus literal checkpoints.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target;
  logic [15:0] instr_in;
  logic [31:0] pc, if_id_pc, fetch_count;
  logic [15:0] if_id_instr, if_id_imm;
  logic        if_id_valid;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_in(instr_in), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_imm(if_id_imm), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  always @(posedge clk) instr_in <= mem[pc[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_ldm(input logic [15:0] w);
    return w[15:11] == 5'b10110;
  endfunction

  // Reference: which address's word is arriving, whether it is real, and any pending LDM.
  logic [31:0] m_next = 0, m_arr = 0, m_pend_addr = 0, m_ipc = 0;
  logic [15:0] m_pend_word = 0, m_instr = 0, m_imm = 0;
  bit          m_arr_ok = 0, m_pend = 0, m_v = 0, last_held = 0, started = 0;
  int unsigned m_cnt = 0;
  logic [31:0] got_pcs [$];

  always @(posedge clk) begin
    logic [15:0] w;
    started   = 1;
    last_held = stall && !branch_taken && !rst;
    if (rst) begin
      m_next = 0; m_arr = 0; m_arr_ok = 0; m_pend = 0; m_v = 0;
      m_instr = 0; m_imm = 0; m_ipc = 0; m_cnt = 0;
    end else if (branch_taken) begin
      m_arr = branch_target; m_next = branch_target + 1; m_arr_ok = 1;
      m_pend = 0; m_v = 0;
    end else if (!stall) begin
      w   = mem[m_arr[7:0]];
      m_v = 0;
      if (m_arr_ok) begin
        if (m_pend) begin
          m_instr = m_pend_word; m_ipc = m_pend_addr; m_imm = w; m_v = 1; m_pend = 0;
        end else if (is_ldm(w)) begin
          m_pend = 1; m_pend_word = w; m_pend_addr = m_arr;
        end else begin
          m_instr = w; m_ipc = m_arr; m_imm = 0; m_v = 1;
        end
      end
      if (m_v) m_cnt++;
      m_arr = m_next; m_next = m_next + 1; m_arr_ok = 1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_pc;
    #3;
    if (started) begin
      exp_pc = rst ? 32'd0 : branch_taken ? branch_target : stall ? m_arr : m_next;
      chk("pc", pc, exp_pc);
      chk("if_id_valid", if_id_valid, m_v);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_imm", if_id_imm, m_imm);
      chk("if_id_pc", if_id_pc, m_ipc);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_cnt);
`else
      chk("fetch_count", fetch_count, 0);
`endif
      if (if_id_valid && !last_held) got_pcs.push_back(if_id_pc);
    end
  end

  task automatic cyc(input bit r, input bit s, input bit b, input logic [31:0] t);
    @(negedge clk); #1;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk); #1;
  endtask

  logic [31:0] exp_pcs [14];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h2000 + 16'(i);
    mem[4] = 16'hB004;
    mem[5] = 16'hBEEF;
    rst = 1; stall = 0; branch_taken = 0; branch_target = 0;
    exp_pcs = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h6, 32'h7, 32'h10, 32'h11,
                32'h20, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1};

    repeat (3) cyc(1, 0, 0, 0);
    chk("reset valid", if_id_valid, 0);
    chk("reset count", fetch_count, 0);
    cyc(0, 0, 0, 0);
    chk("first edge bubble", if_id_valid, 0);
    cyc(0, 0, 0, 0);
    chk("first valid", if_id_valid, 1);
    chk("first pc", if_id_pc, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("stall pc", pc, 2);
    cyc(0, 1, 0, 0);
    chk("stall ifid", if_id_pc, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ldm bubble", if_id_valid, 0);
    cyc(0, 0, 0, 0);
    chk("ldm instr", if_id_instr, 16'hB004);
    chk("ldm imm", if_id_imm, 16'hBEEF);
    chk("ldm pc", if_id_pc, 4);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk); #1;
    stall = 1; branch_taken = 1; branch_target = 32'h10;
    #1 chk("branch pc", pc, 32'h10);
    @(posedge clk); #1;
    chk("branch bubble", if_id_valid, 0);
    cyc(0, 0, 0, 0);
    chk("branch target pc", if_id_pc, 32'h10);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h4);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h20);
    cyc(0, 0, 0, 0);
    chk("s_imm drop pc", if_id_pc, 32'h20);
    cyc(0, 0, 1, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 0);
    chk("wrap pc", if_id_pc, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("count mid", fetch_count, 12);
`else
    chk("count mid", fetch_count, 0);
`endif
    cyc(0, 0, 1, 32'h4);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst mid ldm", if_id_valid, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("post rst pc", if_id_pc, 0);
    chk("post rst imm", if_id_imm, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk); #4;

    chk("pulse count", got_pcs.size(), 14);
    for (int i = 0; i < 14 && i < got_pcs.size(); i++) chk("pulse order", got_pcs[i], exp_pcs[i]);
`ifdef FETCH_PERF_CNT_EN
    chk("count end", fetch_count, 2);
`else
    chk("count end", fetch_count, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
